// File: rtl/fnd_scan_display.sv
// fnd_scan_display
//   Converts a 14-bit binary value into four BCD digits with a sequential
//   shift-add-3 engine, then time-multiplexes the digits onto a 4-digit
//   common-anode seven-segment display (active-low) with optional
//   leading-zero blanking.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-high reset
//   i_value    binary value to display (values above 9999 show as 9999)
//   i_valid    one-cycle strobe, i_value sampled while high
//   fnd_com    digit enables, active-low one-hot, bit0 = ones digit
//   fnd_data   segments {dp,g,f,e,d,c,b,a}, active-low
//   o_busy     high while a conversion is in progress
//   o_disp_bcd currently displayed BCD {thousands,hundreds,tens,ones}
module fnd_scan_display #(
    parameter int CLK_FREQ_HZ   = 100_000_000,
    parameter int SCAN_HZ       = 1000,
    parameter int BLANK_LEADING = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] i_value,
    input  logic        i_valid,
    output logic [3:0]  fnd_com,
    output logic [7:0]  fnd_data,
    output logic        o_busy,
    output logic [15:0] o_disp_bcd
);

    localparam int              DIV       = CLK_FREQ_HZ / SCAN_HZ;
    localparam int              CNT_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV - 1);
    localparam logic            BLANK_EN  = (BLANK_LEADING != 0);
    localparam logic [13:0]     VALUE_MAX = 14'd9999;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_LOAD = 2'd2;

    // Four decimal digits cannot hold more than 9999.
    function automatic logic [13:0] sat_value(input logic [13:0] v);
        return (v > VALUE_MAX) ? VALUE_MAX : v;
    endfunction

    // Add 3 to every nibble >= 5 so the following left shift carries
    // correctly into the next decimal digit.
    function automatic logic [15:0] dabble_adjust(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (b[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] seg_decode(input logic [3:0] nib, input logic blank);
        logic [7:0] s;
        case (nib)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return blank ? 8'hFF : s;
    endfunction

    function automatic logic [3:0] com_decode(input logic [1:0] idx);
        case (idx)
            2'd0:    return 4'b1110;
            2'd1:    return 4'b1101;
            2'd2:    return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    logic [1:0]       state_q, state_d;
    logic [13:0]      bin_q, bin_d;
    logic [15:0]      bcd_q, bcd_d;
    logic [3:0]       iter_q, iter_d;
    logic             busy_q, busy_d;
    logic [15:0]      disp_q, disp_d;
    logic             pend_q, pend_d;
    logic [13:0]      pend_val_q, pend_val_d;
    logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]       scan_idx_q, scan_idx_d;
    logic [3:0]       com_q, com_d;
    logic [7:0]       data_q, data_d;
    logic [29:0]      shift_w;
    logic [3:0]       nib_w;
    logic             blank_w;

    // Conversion control and the single-entry pending slot.
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        iter_d     = iter_q;
        busy_d     = busy_q;
        disp_d     = disp_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        shift_w    = {dabble_adjust(bcd_q), bin_q} << 1;

        case (state_q)
            ST_IDLE: begin
                if (pend_q || i_valid) begin
                    bin_d   = sat_value(pend_q ? pend_val_q : i_value);
                    bcd_d   = '0;
                    iter_d  = 4'd14;
                    busy_d  = 1'b1;
                    state_d = ST_CONV;
                    pend_d  = 1'b0;
                    // A strobe arriving while the pending value is taken
                    // becomes the next pending value rather than being lost.
                    if (pend_q && i_valid) begin
                        pend_d     = 1'b1;
                        pend_val_d = i_value;
                    end
                end
            end
            ST_CONV: begin
                bcd_d  = shift_w[29:14];
                bin_d  = shift_w[13:0];
                iter_d = iter_q - 4'd1;
                if (iter_q == 4'd1) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                disp_d  = bcd_q;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Strobes during CONV or LOAD never abort the conversion; last one wins.
        if (state_q != ST_IDLE && i_valid) begin
            pend_d     = 1'b1;
            pend_val_d = i_value;
        end
    end

    // Free-running digit scan, independent of conversion.
    always_comb begin
        scan_cnt_d = (scan_cnt_q == CNT_MAX) ? '0 : scan_cnt_q + CNT_W'(1);
        scan_idx_d = (scan_cnt_q == CNT_MAX) ? scan_idx_q + 2'd1 : scan_idx_q;

        // A digit blanks when it and every higher digit are zero.
        case (scan_idx_q)
            2'd0:    begin nib_w = disp_q[3:0];   blank_w = 1'b0; end
            2'd1:    begin nib_w = disp_q[7:4];   blank_w = BLANK_EN && (disp_q[15:4]  == 12'd0); end
            2'd2:    begin nib_w = disp_q[11:8];  blank_w = BLANK_EN && (disp_q[15:8]  == 8'd0); end
            default: begin nib_w = disp_q[15:12]; blank_w = BLANK_EN && (disp_q[15:12] == 4'd0); end
        endcase

        com_d  = com_decode(scan_idx_q);
        data_d = seg_decode(nib_w, blank_w);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            iter_q     <= '0;
            busy_q     <= 1'b0;
            disp_q     <= '0;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            scan_cnt_q <= '0;
            scan_idx_q <= '0;
            com_q      <= 4'b1110;
            data_q     <= 8'hC0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            iter_q     <= iter_d;
            busy_q     <= busy_d;
            disp_q     <= disp_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
            com_q      <= com_d;
            data_q     <= data_d;
        end
    end

    assign fnd_com    = com_q;
    assign fnd_data   = data_q;
    assign o_busy     = busy_q;
    assign o_disp_bcd = disp_q;

endmodule

// File: tb/tb_fnd_scan_display.sv
module tb_fnd_scan_display;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [13:0] i_value = '0;
    logic        i_valid = 1'b0;

    logic [3:0]  com0, com1;
    logic [7:0]  data0, data1;
    logic        busy0, busy1;
    logic [15:0] bcd0, bcd1;

    always #5 clk = ~clk;

    fnd_scan_display #(.CLK_FREQ_HZ(1000), .SCAN_HZ(250), .BLANK_LEADING(1)) u_blank (
        .clk(clk), .reset(reset), .i_value(i_value), .i_valid(i_valid),
        .fnd_com(com0), .fnd_data(data0), .o_busy(busy0), .o_disp_bcd(bcd0)
    );

    fnd_scan_display #(.CLK_FREQ_HZ(1000), .SCAN_HZ(250), .BLANK_LEADING(0)) u_full (
        .clk(clk), .reset(reset), .i_value(i_value), .i_valid(i_valid),
        .fnd_com(com1), .fnd_data(data1), .o_busy(busy1), .o_disp_bcd(bcd1)
    );

    typedef struct {
        int val;
        int done;
    } conv_t;

    conv_t sb_q[$];
    conv_t sched_q[$];
    int    n_cmp = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    n_edges = 0;
    int    n_conv = 0;
    int    free_at = 0;
    bit    m_pend = 0;
    int    m_pend_val = 0;
    int    cur_val = 0;
    int    prev_val = 0;
    bit    prev_busy = 0;
    int    busy_cnt = 0;
    int    mon_dig;
    bit    mon_busy_exp;
    conv_t mon_e;

    logic [7:0] seg_tab [0:9] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                  8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge reset) begin
        if (reset) n_edges <= 0;
        else       n_edges <= n_edges + 1;
    end

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    function automatic logic [7:0] exp_seg(input int v, input int k, input bit blank_en);
        int p;
        p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        if (blank_en && k > 0 && v < p) return 8'hFF;
        return seg_tab[(v / p) % 10];
    endfunction

    function automatic logic [3:0] exp_com(input int n);
        int idx;
        logic [3:0] c;
        idx = (n == 0) ? 0 : ((n - 1) / 4) % 4;
        c = 4'b0001 << idx;
        return ~c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic start_conv(input int val);
        conv_t e;
        e.val  = (val > 9999) ? 9999 : val;
        e.done = cyc + 16;
        sb_q.push_back(e);
        sched_q.push_back(e);
        free_at = cyc + 16;
    endtask

    // Drive one cycle of stimulus and advance the reference model.
    task automatic step(input bit v, input int val);
        i_valid = v;
        i_value = v ? 14'(val) : 14'($urandom);
        if (cyc >= free_at) begin
            if (m_pend) begin
                start_conv(m_pend_val);
                m_pend = 0;
                if (v) begin
                    m_pend = 1;
                    m_pend_val = val;
                end
            end else if (v) begin
                start_conv(val);
            end
        end else if (v) begin
            m_pend = 1;
            m_pend_val = val;
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0);
    endtask

    task automatic reset_checks();
        chk("rst_disp_blank", bcd0, 16'h0000);
        chk("rst_disp_full", bcd1, 16'h0000);
        chk("rst_busy_blank", busy0, 1'b0);
        chk("rst_busy_full", busy1, 1'b0);
        chk("rst_com_blank", com0, 4'b1110);
        chk("rst_com_full", com1, 4'b1110);
        chk("rst_data_blank", data0, 8'hC0);
        chk("rst_data_full", data1, 8'hC0);
    endtask

    // Monitor: continuous display model plus conversion scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            cur_val = 0;
            prev_val = 0;
            prev_busy = 0;
            busy_cnt = 0;
        end else begin
            while (sched_q.size() > 0 && sched_q[0].done <= cyc) begin
                cur_val = sched_q[0].val;
                void'(sched_q.pop_front());
            end
            chk("disp_bcd_blank", bcd0, to_bcd(cur_val));
            chk("disp_bcd_full", bcd1, to_bcd(cur_val));
            mon_busy_exp = (sched_q.size() > 0) && (cyc >= sched_q[0].done - 15);
            chk("busy_blank", busy0, mon_busy_exp);
            chk("busy_full", busy1, mon_busy_exp);
            chk("fnd_com_blank", com0, exp_com(n_edges));
            chk("fnd_com_full", com1, exp_com(n_edges));
            mon_dig = (n_edges == 0) ? 0 : ((n_edges - 1) / 4) % 4;
            chk("fnd_data_blank", data0, exp_seg(prev_val, mon_dig, 1'b1));
            chk("fnd_data_full", data1, exp_seg(prev_val, mon_dig, 1'b0));
            if (busy0) busy_cnt++;
            if (prev_busy && !busy0) begin
                n_conv++;
                chk("conv_expected", (sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    mon_e = sb_q.pop_front();
                    chk("sb_value", bcd0, to_bcd(mon_e.val));
                    chk("sb_done_cycle", cyc, mon_e.done);
                end
                chk("busy_length", busy_cnt, 15);
                busy_cnt = 0;
            end
            prev_busy = busy0;
            prev_val = cur_val;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int r;
        int val;
        bit v;
        int picks [0:7];
        picks = '{0, 9, 10, 99, 100, 999, 1000, 9999};

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_checks();
        reset = 1'b0;

        step(1, 1234); idle(40);
        step(1, 16383); idle(20);
        step(1, 10000); idle(20);
        step(1, 9999); idle(20);
        step(1, 7); idle(40);
        step(1, 0); idle(20);
        step(1, 70); idle(20);
        step(1, 1005); idle(20);

        base = n_conv;
        step(1, 100); idle(1); step(1, 200); idle(4); step(1, 300); idle(40);
        chk("burst_conversions", n_conv - base, 2);
        chk("burst_final", bcd0, 16'h0300);

        step(1, 50); idle(14); step(1, 60); idle(40);
        chk("load_cycle_strobe", bcd0, 16'h0060);

        step(1, 1234); idle(5);
        #2;
        reset = 1'b1;
        #1;
        reset_checks();
        sb_q.delete();
        sched_q.delete();
        m_pend = 0;
        free_at = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("post_reset_disp", bcd0, 16'h0000);
        idle(20);

        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 15) == 0);
            if (cyc >= free_at && m_pend) v = 0;
            r = $urandom_range(0, 3);
            case (r)
                0: val = $urandom_range(10000, 16383);
                1: val = $urandom_range(0, 99);
                2: val = $urandom_range(0, 9999);
                default: val = picks[$urandom_range(0, 7)];
            endcase
            step(v, val);
        end
        idle(60);
        chk("drain_sb", sb_q.size(), 0);
        chk("drain_sched", sched_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fnd_scan_display.md
Name: fnd_scan_display

Overview:
- Downstream consumer of the slave's received counter.
- Takes a 14-bit binary value qualified by a one-cycle valid strobe and converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Time-multiplexes the digits onto a 4-digit common-anode seven-segment display, active-low, with leading-zero blanking.
- Sits between the SPI slave data path and the board FND pins.

Parameters:
- CLK_FREQ_HZ, 100_000_000, system clock frequency.
- SCAN_HZ, 1000, digit switch rate. Each digit is held for DIV = CLK_FREQ_HZ/SCAN_HZ cycles, so a full frame is 4*DIV cycles.
- BLANK_LEADING, 1, 1 = blank leading zeros; 0 = show all four digits.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- i_value  input  14  binary value to display
- i_valid  input  1  one-cycle strobe; i_value sampled when high
- fnd_com  output  4  digit enables, active-low, one-hot-low; bit0 = ones digit
- fnd_data  output  8  segments {dp,g,f,e,d,c,b,a}, active-low
- o_busy  output  1  high while a conversion is in progress
- o_disp_bcd  output  16  currently displayed BCD {thousands,hundreds,tens,ones}, for debug and verification

Behaviour:
- Reset is asynchronous, active-high, on clk. All flops clear on reset assertion.
- Reset values:
  - o_disp_bcd = 16'h0000
  - o_busy = 0
  - fnd_com = 4'b1110
  - fnd_data = 8'hC0 (digit "0")
  - scan index = 0, scan counter = 0, pending flag = 0
- Input clamp: a sampled value greater than 9999 is replaced by 9999 before conversion.
- FSM states:
  - IDLE:
    - If i_valid or the pending flag is set, load the value (pending value takes priority), clear the pending flag, zero the BCD accumulator and set the iteration counter to 14.
    - Go to CONV; o_busy = 1 from the next cycle.
  - CONV:
    - Each cycle, add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by 1.
    - Decrement the iteration counter. After the 14th shift, go to LOAD.
  - LOAD:
    - o_disp_bcd <= accumulator; o_busy <= 0; go to IDLE.
- Latency: i_valid at cycle N → o_busy high at N+1 → o_disp_bcd updated at the edge ending cycle N+15 (visible N+16). Maximum 16 cycles.
- i_valid while o_busy = 1:
  - Store the value in a single-entry pending register and set the pending flag.
  - A newer strobe overwrites the pending value (last-wins).
  - The in-flight conversion is never aborted.
  - The pending value starts converting on the first IDLE cycle after LOAD.
- i_valid in the same cycle as LOAD: goes to pending; it converts on the following IDLE cycle.
- Scan:
  - Free-running counter 0..DIV-1. On wrap, scan index advances 0→1→2→3→0.
  - The scan runs independently of conversion; o_disp_bcd may change mid-frame.
- Outputs are registered: fnd_com and fnd_data update one cycle after the scan index or o_disp_bcd change. No combinational path from i_value to the pins.
- fnd_com encoding by index: 0 → 1110, 1 → 1101, 2 → 1011, 3 → 0111.
- Segment codes (dp off, bit7 = 1):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, blank=FF.
  - A nibble > 9 cannot occur; if forced, it decodes to FF.
- Blanking, when BLANK_LEADING = 1:
  - Digit k (k = 1..3) shows FF if its nibble and all higher nibbles are zero.
  - Digit 0 is always shown.
  - Examples: 0 → "   0"; 70 → "  70"; 1005 → "1005".
- Reset mid-conversion: the conversion is discarded and the pending value is lost; the display returns to "0".

Test Plan:
- Reset asserted during CONV of 1234 → all outputs at reset values immediately. After release, o_disp_bcd = 0000 and fnd_com = 1110 with fnd_data = C0.
- i_valid with i_value = 1234 → o_busy high for exactly 15 cycles. o_disp_bcd = 16'h1234 by cycle N+16. Over one frame, digits 0..3 show 99, B0, A4, F9.
- i_value = 16383 → o_disp_bcd = 16'h9999. i_value = 10000 → 9999. i_value = 9999 → 9999.
- i_value = 7 with BLANK_LEADING = 1 → per frame, fnd_data = F8, FF, FF, FF. Same value with BLANK_LEADING = 0 → F8, C0, C0, C0.
- Strobes of 100, then 200 two cycles later, then 300 five cycles later, all inside one conversion → 100 displays first, then exactly one more conversion, and the final o_disp_bcd = 16'h0300; 200 is never displayed.
- With CLK_FREQ_HZ = 1000 and SCAN_HZ = 250 (DIV = 4) → fnd_com changes every 4 cycles in the order 1110, 1101, 1011, 0111, 1110. Never more than one bit low, never all high after reset.
